// File: rtl/i2s_pkg.sv
// i2s_pkg: constants and helpers shared by the I2S transmitter, a future receiver and benches.
//   LEFT / RIGHT  : lrclk polarity for the left and right channel slots.
//   frame_cycles(): length of one stereo frame in CLK cycles.
package i2s_pkg;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // Two slots of data_width bits, each bit lasting 2*bclk_half CLK cycles.
  function automatic int unsigned frame_cycles(input int unsigned data_width,
                                               input int unsigned bclk_half);
    return 2 * data_width * 2 * bclk_half;
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: stereo sample-pair stream with a valid/ready handshake.
//   x_l, x_r : left/right samples, two's complement
//   valid    : pair is valid (source -> sink)
//   ready    : sink can accept a pair (sink -> source)
interface i2s_tx_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] x_l;
  logic [DATA_WIDTH-1:0] x_r;
  logic                  valid;
  logic                  ready;

  modport master (output x_l, output x_r, output valid, input ready);
  modport slave  (input x_l, input x_r, input valid, output ready);

endinterface

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: bit-clock divider and frame bit counter for the I2S transmitter.
//   CLK, rst : system clock, synchronous active-high reset
//   bclk     : I2S bit clock (registered)
//   fall_c   : strobe, high on the CLK cycle whose edge takes bclk 1->0
//   b_nxt_c  : value the bit counter takes at that falling event
module i2s_clk_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BCLK_HALF  = 4
) (
  input  logic                            CLK,
  input  logic                            rst,
  output logic                            bclk,
  output logic                            fall_c,
  output logic [$clog2(2*DATA_WIDTH)-1:0] b_nxt_c
);

  localparam int unsigned FW = 2 * DATA_WIDTH;
  localparam int unsigned BW = $clog2(FW);
  localparam int unsigned DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] b;
  logic          wrap_c;

  assign wrap_c  = (div_cnt == DW'(BCLK_HALF - 1));
  assign fall_c  = wrap_c && bclk;
  assign b_nxt_c = (b == BW'(FW - 1)) ? '0 : b + BW'(1);

  // Divider, bit clock and bit counter; b resets to the last slot so the
  // first falling event lands on b=0.
  always_ff @(posedge CLK) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      b       <= BW'(FW - 1);
    end else begin
      if (wrap_c) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (fall_c) begin
        b <= b_nxt_c;
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: serializes stereo sample pairs into a standard I2S stream.
//   CLK, rst : system clock, synchronous active-high reset
//   in_if    : sample-pair stream (slave side), one-entry holding buffer
//   bclk     : I2S bit clock
//   lrclk    : word select, 0 = left, 1 = right
//   sdata    : serial data, MSB first, one-bit delayed after lrclk
//   underrun : one-cycle pulse when a frame starts with no pair buffered
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BCLK_HALF  = 4
) (
  input  logic     CLK,
  input  logic     rst,
  i2s_tx_if.slave  in_if,
  output logic     bclk,
  output logic     lrclk,
  output logic     sdata,
  output logic     underrun
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned FW = 2 * W;
  localparam int unsigned BW = $clog2(FW);

  logic          fall;
  logic [BW-1:0] b_nxt;
  logic          empty;
  logic [W-1:0]  buf_l;
  logic [W-1:0]  buf_r;
  logic [FW-1:0] sr;
  logic          accept;
  logic          load;

  i2s_clk_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .BCLK_HALF  (BCLK_HALF)
  ) u_clk_gen (
    .CLK     (CLK),
    .rst     (rst),
    .bclk    (bclk),
    .fall_c  (fall),
    .b_nxt_c (b_nxt)
  );

  // ready comes straight from the buffer-empty flop, never from valid.
  assign in_if.ready = empty;
  assign accept      = in_if.valid && empty;
  assign load        = fall && (b_nxt == BW'(1));

  // Holding buffer: a handshake on the load cycle refills it for the next frame.
  always_ff @(posedge CLK) begin
    if (rst) begin
      empty <= 1'b1;
      buf_l <= '0;
      buf_r <= '0;
    end else begin
      if (accept) begin
        empty <= 1'b0;
        buf_l <= in_if.x_l;
        buf_r <= in_if.x_r;
      end else if (load) begin
        empty <= 1'b1;
      end
    end
  end

  // Shift register, word select, serial data and underrun flag, all moved on
  // falling bclk so they are stable across the receiver's rising-edge sample.
  always_ff @(posedge CLK) begin
    if (rst) begin
      sr       <= '0;
      lrclk    <= LEFT;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fall) begin
        lrclk <= (b_nxt >= BW'(W)) ? RIGHT : LEFT;
        if (load) begin
          if (empty) begin
            sr       <= '0;
            sdata    <= 1'b0;
            underrun <= 1'b1;
          end else begin
            sr    <= {buf_l, buf_r};
            sdata <= buf_l[W-1];
          end
        end else begin
          sr    <= {sr[FW-2:0], 1'b0};
          sdata <= sr[FW-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx with a time-based reference model
// and a bench-side I2S receiver.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int W     = 32;
  localparam int H     = 4;
  localparam int FW    = 2 * W;
  localparam int FRAME = int'(frame_cycles(W, H));

  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic bclk, lrclk, sdata, underrun;

  i2s_tx_if #(.DATA_WIDTH(W)) s_if ();

  i2s_tx #(.DATA_WIDTH(W), .BCLK_HALF(H)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .in_if    (s_if),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state: n = CLK edges since reset released.
  int             n = 0;
  logic           m_full = 1'b0;
  logic [W-1:0]   m_l = '0, m_r = '0;
  logic [FW-1:0]  cur_frame = '0;
  logic           m_hs = 1'b0;
  logic           ur_exp = 1'b0;
  logic [FW-1:0]  sentq[$];

  // Monitor / receiver state.
  logic           prev_bclk = 1'b0;
  int             first_rise_n = -1, first_fall_n = -1;
  int             ur_cnt = 0, ur_first_n = -1, ur_last_n = 0, ur_gap_bad = 0;
  int             sdata_ones = 0, rdy_hi = 0;
  logic [W-1:0]   rx_acc = '0, rx_l = '0;
  logic           rx_prev_lr = 1'b0;
  logic [FW-1:0]  rxq[$];

  function automatic logic [FW-1:0] rx_at(input int i);
    if (i < rxq.size()) return rxq[i];
    return 'x;
  endfunction

  // Model update at each edge, then compare outputs 1 time unit later.
  always @(posedge CLK) begin
    int   f, bb;
    logic ld, e_bclk, e_lr, e_sd, e_rdy, e_ur;
    logic [W-1:0] word;
    if (rst) begin
      n = 0; m_full = 1'b0; m_l = '0; m_r = '0; cur_frame = '0;
      m_hs = 1'b0; ur_exp = 1'b0; sentq.delete();
    end else begin
      n++;
      m_hs = s_if.valid && !m_full;
      f  = n / (2 * H);
      ld = (n % (2 * H) == 0) && (f >= 2) && ((f - 1) % FW == 1);
      ur_exp = ld && !m_full;
      if (ld) begin
        cur_frame = m_full ? {m_l, m_r} : '0;
        m_full = 1'b0;
      end
      if (m_hs) begin
        m_full = 1'b1; m_l = s_if.x_l; m_r = s_if.x_r;
        sentq.push_back({s_if.x_l, s_if.x_r});
      end
    end
    f      = n / (2 * H);
    bb     = (f >= 1) ? (f - 1) % FW : 0;
    e_bclk = ((n / H) % 2) == 1;
    e_lr   = (f >= 1) && (bb >= W);
    e_sd   = cur_frame[(FW - bb) % FW];
    e_rdy  = !m_full;
    e_ur   = ur_exp;
    #1;
    check("bclk", 64'(bclk), 64'(e_bclk));
    check("lrclk", 64'(lrclk), 64'(e_lr));
    check("sdata", 64'(sdata), 64'(e_sd));
    check("ready", 64'(s_if.ready), 64'(e_rdy));
    check("underrun", 64'(underrun), 64'(e_ur));
    if (rst) begin
      prev_bclk = 1'b0; first_rise_n = -1; first_fall_n = -1;
      ur_cnt = 0; ur_first_n = -1; ur_last_n = 0; ur_gap_bad = 0;
      sdata_ones = 0; rdy_hi = 0; rx_acc = '0; rx_l = '0; rx_prev_lr = 1'b0;
      rxq.delete();
    end else begin
      if (s_if.ready) rdy_hi++;
      if (sdata) sdata_ones++;
      if (underrun) begin
        ur_cnt++;
        if (ur_first_n < 0) ur_first_n = n;
        else if (n - ur_last_n != FRAME) ur_gap_bad++;
        ur_last_n = n;
      end
      if (bclk && !prev_bclk) begin
        if (first_rise_n < 0) first_rise_n = n;
        word = {rx_acc[W-2:0], sdata};
        if (lrclk != rx_prev_lr) begin
          if (rx_prev_lr == LEFT) rx_l = word;
          else rxq.push_back({rx_l, word});
          rx_acc = '0;
        end else begin
          rx_acc = word;
        end
        rx_prev_lr = lrclk;
      end
      if (!bclk && prev_bclk && first_fall_n < 0) first_fall_n = n;
      prev_bclk = bclk;
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    rst = 1'b1;
    repeat (cycles) @(negedge CLK);
    rst = 1'b0;
  endtask

  task automatic wait_n(input int target);
    int g = 0;
    while (n != target && g < 8000) begin
      @(negedge CLK);
      g++;
    end
    check("wait_n", 64'(n), 64'(target));
  endtask

  // Hold a pair on the bus until it is taken (bounded), then drop valid.
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
    int g = 0;
    s_if.x_l = l; s_if.x_r = r; s_if.valid = 1'b1;
    do begin
      @(negedge CLK);
      g++;
    end while (!m_hs && g < 2000);
    check("send_accepted", 64'(m_hs), 64'(1));
    s_if.valid = 1'b0;
  endtask

  initial begin
    int k;
    s_if.valid = 1'b0; s_if.x_l = '0; s_if.x_r = '0;

    // Reset defaults and idle underrun.
    do_reset(3);
    repeat (1100) @(negedge CLK);
    check("first_rise", 64'(first_rise_n), 64'(4));
    check("first_fall", 64'(first_fall_n), 64'(8));
    check("idle_ur_first", 64'(ur_first_n), 64'(16));
    check("idle_ur_count", 64'(ur_cnt), 64'(3));
    check("idle_ur_gap", 64'(ur_gap_bad), 64'(0));
    check("idle_sdata", 64'(sdata_ones), 64'(0));

    // Single pair ahead of the first load.
    do_reset(2);
    send(32'hA5A5_0001, 32'h8000_FFFF);
    wait_n(560);
    check("single_pair", rx_at(0), {32'hA5A5_0001, 32'h8000_FFFF});
    check("single_ur_first", 64'(ur_first_n), 64'(528));

    // First valid exactly on the load cycle.
    do_reset(2);
    wait_n(15);
    s_if.x_l = 32'h1234_5678; s_if.x_r = 32'h9ABC_DEF0; s_if.valid = 1'b1;
    @(negedge CLK);
    check("simul_ready", 64'(s_if.ready), 64'(0));
    s_if.valid = 1'b0;
    wait_n(1100);
    check("simul_ur_first", 64'(ur_first_n), 64'(16));
    check("simul_ur_count", 64'(ur_cnt), 64'(2));
    check("simul_frame0", rx_at(0), 64'h0);
    check("simul_frame1", rx_at(1), {32'h1234_5678, 32'h9ABC_DEF0});

    // Back-to-back streaming over ten frames.
    k = 0;
    s_if.x_l = 32'h1000_0000; s_if.x_r = 32'h8000_0000; s_if.valid = 1'b1;
    do_reset(2);
    repeat (10 * FRAME + 200) begin
      @(negedge CLK);
      if (m_hs) begin
        k++;
        s_if.x_l = 32'h1000_0000 + 32'(k);
        s_if.x_r = 32'h8000_0000 | 32'(k);
      end
    end
    s_if.valid = 1'b0;
    check("stream_rx_count", 64'(rxq.size()), 64'(10));
    check("stream_ur_count", 64'(ur_cnt), 64'(0));
    check("stream_ready_windows", 64'(rdy_hi), 64'(11));
    check("stream_pair1", rx_at(1), {32'h1000_0001, 32'h8000_0001});
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stream_order%0d", i), rx_at(i),
            (i < sentq.size()) ? sentq[i] : 64'hx);
    end

    // Reset mid-frame with the buffer full.
    do_reset(2);
    send(32'h1111_1111, 32'h2222_2222);
    send(32'h3333_3333, 32'h4444_4444);
    wait_n(168);
    check("mid_buffer_full", 64'(s_if.ready), 64'(0));
    rst = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_rst_bclk", 64'(bclk), 64'(0));
    check("mid_rst_lrclk", 64'(lrclk), 64'(0));
    check("mid_rst_sdata", 64'(sdata), 64'(0));
    check("mid_rst_underrun", 64'(underrun), 64'(0));
    check("mid_rst_ready", 64'(s_if.ready), 64'(1));
    @(negedge CLK);
    rst = 1'b0;
    repeat (600) @(negedge CLK);
    check("mid_first_rise", 64'(first_rise_n), 64'(4));
    check("mid_first_fall", 64'(first_fall_n), 64'(8));
    check("mid_ur_first", 64'(ur_first_n), 64'(16));
    check("mid_frame0", rx_at(0), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serial audio transmitter for the guitar-effects datapath: accepts processed stereo sample pairs (e.g. the `y` output of the delay effect) over a valid/ready handshake and serializes them as a standard I2S stream (BCLK, LRCLK, SDATA) toward the DAC/codec. It generates its own bit and word clocks from `CLK`, which makes it the output-side counterpart of the sample stream that the effects consume.

## Interface
Parameters:
- `DATA_WIDTH`, 32: sample width in bits, which is also the I2S slot width. Must be at least 2.
- `BCLK_HALF`, 4: `CLK` cycles per BCLK half-period. Must be at least 1.

Ports:
- `CLK`  in  1: system clock. This is the single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `x_l`  in  DATA_WIDTH: left sample, two's complement.
- `x_r`  in  DATA_WIDTH: right sample, two's complement.
- `valid`  in  1: the `x_l`/`x_r` pair is valid.
- `ready`  out  1: the holding buffer is empty, so a pair can be accepted.
- `bclk`  out  1: I2S bit clock.
- `lrclk`  out  1: I2S word select. 0 = left, 1 = right.
- `sdata`  out  1: I2S serial data, MSB first.
- `underrun`  out  1: one-`CLK` pulse when a frame starts with no sample available.

## Operation
- **Handshake.** A pair is accepted on any `CLK` edge where `valid && ready`. It goes into a one-entry holding buffer and `ready` drops the next cycle. `ready` is driven directly from buffer-empty, with no combinational path from `valid`.
- **Divider.** `div_cnt` counts 0..`BCLK_HALF`-1. On wrap, `bclk` toggles. A 1→0 toggle is a *falling event*.
- **Bit counter.** `b` counts 0..2·`DATA_WIDTH`-1 and advances once per falling event, wrapping to 0.
- **Word select.**
  - `lrclk` is updated on falling events: `lrclk` = 0 for b in [0, W-1] and 1 for b in [W, 2W-1], where W = `DATA_WIDTH`.
- **Data.** `sdata` is updated on falling events and carries the I2S one-bit delay:
  - Left MSB is sent at b=1 and left LSB at b=W.
  - Right MSB is sent at b=W+1 and right LSB at b=0 of the following frame.
- **Frame load (falling event with b=1).**
  - A 2W-bit shift register loads {buffer.l, buffer.r} and the buffer is marked empty.
  - If the buffer was empty at the start of that cycle, the register loads all zeros and `underrun` pulses for one `CLK` cycle.
  - A handshake in the same cycle fills the buffer for the *next* frame. There is no bypass.
- **Shifting.** On all other falling events the register shifts left and `sdata` takes its MSB.
- **Reset.**
  - Every state clears: buffer empty, shift register 0, `div_cnt` = 0, `b` = 2W-1 (so the first falling event lands at b=0).
  - Reset values of the outputs: `bclk`=0, `lrclk`=0, `sdata`=0, `underrun`=0, `ready`=1.
  - Reset asserted mid-frame aborts the frame and discards any buffered pair. No `underrun` pulse is generated during reset.

## Timing
- BCLK period = 2·`BCLK_HALF` `CLK` cycles. With defaults that is 8 cycles, so a frame is 2·W·8 = 512 `CLK` cycles.
- After `rst` deasserts:
  - The first `bclk` rising edge occurs `BCLK_HALF` cycles later.
  - The first falling event (b=0) occurs 2·`BCLK_HALF` cycles later.
  - The first frame load (b=1) occurs 4·`BCLK_HALF` cycles later.
- All outputs are registered and change only on the `CLK` edge of a divider wrap. `sdata` and `lrclk` are stable across every `bclk` rising edge, which is where the receiver samples.
- Latency: a pair accepted before a b=1 falling event has its left MSB on `sdata` from that event. A pair accepted on that exact cycle waits one frame.
- `ready` re-rises on the `CLK` cycle after the b=1 load. The upstream source therefore has about one frame to supply the next pair.
- Throughput is one pair per frame. A pair that is offered while the buffer is full stalls with `ready`=0.

## Structure
- Shared package `i2s_pkg`:
  - Constants `LEFT`=0 and `RIGHT`=1 for `lrclk` polarity.
  - A function computing frame length in `CLK` cycles, `2*DATA_WIDTH*2*BCLK_HALF`, for reuse by a future `i2s_rx` and by benches.
- One sub-module, `i2s_clk_gen`, owns `div_cnt`, `bclk`, `b` and the falling-event strobe. It is parameterized by `DATA_WIDTH` and `BCLK_HALF`.
- The top level holds the buffer, the shift register, `lrclk`/`sdata` and `underrun`.

## Test plan
- **Reset defaults.** Hold `rst`=1 for 3 cycles, then release. Required: `bclk`/`lrclk`/`sdata`/`underrun` = 0 and `ready`=1 while in reset; first `bclk` rise at 4 cycles and first fall at 8 cycles (defaults).
- **Single pair.** Offer `x_l`=32'hA5A5_0001, `x_r`=32'h8000_FFFF before the first load. Required: a bench-side I2S receiver sampling on `bclk` rising recovers exactly that pair, with `lrclk`=0 for the left bits and 1 for the right bits, and the MSB one BCLK after the `lrclk` edge.
- **Underrun.** After reset, keep `valid`=0. Required: `underrun` pulses once per frame, 512 cycles apart, and `sdata` stays 0.
- **Back-to-back streaming.** Drive `valid`=1 continuously with an incrementing counter pattern for 10 frames. Required: every pair is received in order, with no underrun and no duplicates; `ready` is high for at most one window per frame.
- **Simultaneous load and handshake.** Present the first `valid` exactly on the b=1 load cycle. Required: that frame is zeros with `underrun`=1, and the pair appears in the next frame.
- **Reset mid-frame.** Assert `rst` at b=20 with the buffer full. Required: the buffer is discarded, outputs return to reset values, and the frame timing restarts from b=0 as in the reset-defaults scenario.
